// File: rtl/kronos_types.sv
// Shared types for the kronos SRAM arbiter: the registered owner of the
// access launched in the previous cycle.
package kronos_types;

  typedef enum logic [1:0] {
    OWNER_NONE,
    OWNER_INSTR,
    OWNER_DATA
  } arb_owner_t;

endpackage

// File: rtl/spsram32_model.sv
// Single-port 32-bit SRAM with byte write mask and one-cycle registered read.
// Depth is 2**MEMSIZE words; contents are not reset.
module spsram32_model #(
  parameter int MEMSIZE = 11
) (
  input  logic               clk,
  input  logic [MEMSIZE-1:0] addr,
  input  logic [31:0]        wdata,
  input  logic [3:0]         wmask,
  input  logic               en,
  input  logic               wren,
  output logic [31:0]        rdata
);

  logic [31:0] mem [2**MEMSIZE];

  always_ff @(posedge clk) begin
    if (en) begin
      if (wren) begin
        for (int b = 0; b < 4; b++)
          if (wmask[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/kronos_spsram_arbiter.sv
// Shares one single-port SRAM between instruction fetch and data access.
// Data wins collisions unless the fetch side has lost STARVE_LIMIT cycles in a row.
module kronos_spsram_arbiter
  import kronos_types::*;
#(
  parameter int MEMSIZE      = 11,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instr_addr,
  input  logic               instr_req,
  output logic               instr_gnt,
  output logic [31:0]        instr_data,
  input  logic [31:0]        data_addr,
  input  logic [31:0]        data_wr_data,
  input  logic [3:0]         data_wr_mask,
  input  logic               data_rd_req,
  input  logic               data_wr_req,
  output logic               data_gnt,
  output logic [31:0]        data_rd_data,
  output logic [MEMSIZE-1:0] mem_addr,
  output logic [31:0]        mem_wdata,
  output logic [3:0]         mem_wmask,
  output logic               mem_en,
  output logic               mem_wren,
  input  logic [31:0]        mem_rdata,
  output logic [15:0]        conflict_cnt
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt;
  arb_owner_t    owner;
  logic          data_req, starved, data_win, instr_win;
  logic          unused_addr_bits;

  assign data_req  = data_rd_req | data_wr_req;
  assign starved   = (starve_cnt == SW'(STARVE_LIMIT));
  assign data_win  = data_req & ~(instr_req & starved);
  assign instr_win = instr_req & ~data_win;

  // A simultaneous read+write request is a single write access.
  assign mem_en    = instr_req | data_req;
  assign mem_wren  = data_wr_req & data_win;
  assign mem_addr  = data_win ? data_addr[2 +: MEMSIZE] : instr_addr[2 +: MEMSIZE];
  assign mem_wdata = data_wr_data;
  assign mem_wmask = data_wr_mask;

  assign instr_data   = mem_rdata;
  assign data_rd_data = mem_rdata;
  assign instr_gnt    = (owner == OWNER_INSTR);
  assign data_gnt     = (owner == OWNER_DATA);

  // Upper and byte-offset address bits alias by design.
  assign unused_addr_bits = ^{instr_addr[31:2+MEMSIZE], instr_addr[1:0],
                              data_addr[31:2+MEMSIZE], data_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner        <= OWNER_NONE;
      starve_cnt   <= '0;
      conflict_cnt <= '0;
    end else begin
      if (instr_win)     owner <= OWNER_INSTR;
      else if (data_win) owner <= OWNER_DATA;
      else               owner <= OWNER_NONE;

      // Losing is impossible once starved, so this never passes STARVE_LIMIT.
      if (instr_req & data_win) starve_cnt <= starve_cnt + 1'b1;
      else                      starve_cnt <= '0;

      if (instr_req & data_req & (conflict_cnt != 16'hFFFF))
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_kronos_spsram_arbiter.sv
// Randomized and directed bench for kronos_spsram_arbiter with an SRAM model,
// checked each cycle against a transaction-level reference.
module tb_kronos_spsram_arbiter;

  localparam int MEMSIZE = 11;
  localparam int LIMIT   = 4;
  localparam int DEPTH   = 2**MEMSIZE;

  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] instr_addr = '0, data_addr = '0, data_wr_data = '0;
  logic [3:0]  data_wr_mask = '0;
  logic        instr_req = 1'b0, data_rd_req = 1'b0, data_wr_req = 1'b0;
  logic        instr_gnt, data_gnt, mem_en, mem_wren;
  logic [31:0] instr_data, data_rd_data, mem_wdata, mem_rdata;
  logic [MEMSIZE-1:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [15:0] conflict_cnt;

  always #5 clk = ~clk;

  kronos_spsram_arbiter #(.MEMSIZE(MEMSIZE), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .instr_addr(instr_addr), .instr_req(instr_req), .instr_gnt(instr_gnt),
    .instr_data(instr_data),
    .data_addr(data_addr), .data_wr_data(data_wr_data), .data_wr_mask(data_wr_mask),
    .data_rd_req(data_rd_req), .data_wr_req(data_wr_req), .data_gnt(data_gnt),
    .data_rd_data(data_rd_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_en(mem_en), .mem_wren(mem_wren), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  spsram32_model #(.MEMSIZE(MEMSIZE)) sram (
    .clk(clk), .addr(mem_addr), .wdata(mem_wdata), .wmask(mem_wmask),
    .en(mem_en), .wren(mem_wren), .rdata(mem_rdata)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference state: previous winner (0 none, 1 instr, 2 data-read, 3 data-write).
  bit [31:0] ref_mem [DEPTH];
  int        m_prev = 0, m_loss = 0, m_conf = 0;
  bit [31:0] m_rd;
  int        cnt_ig = 0, cnt_dg = 0;
  logic      s_ig, s_dg;
  logic [15:0] s_cc;
  logic [31:0] s_data;
  logic [MEMSIZE-1:0] s_addr;

  function automatic int widx(input logic [31:0] a);
    return int'(a[2 +: MEMSIZE]);
  endfunction

  // One clock: check outputs at negedge, advance reference at posedge.
  task automatic tick();
    int  win;
    bit  dreq;
    @(negedge clk);
    if (rst) begin m_prev = 0; m_loss = 0; m_conf = 0; end
    s_ig = instr_gnt; s_dg = data_gnt; s_cc = conflict_cnt;
    s_data = data_rd_data; s_addr = mem_addr;
    cnt_ig += int'(instr_gnt); cnt_dg += int'(data_gnt);
    chk("instr_gnt", 32'(instr_gnt), 32'(m_prev == 1));
    chk("data_gnt", 32'(data_gnt), 32'(m_prev == 2 || m_prev == 3));
    if (m_prev == 1) chk("instr_data", instr_data, m_rd);
    if (m_prev == 2) chk("data_rd_data", data_rd_data, m_rd);
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));

    dreq = data_rd_req | data_wr_req;
    if (dreq && !(instr_req && m_loss == LIMIT)) win = data_wr_req ? 3 : 2;
    else if (instr_req) win = 1;
    else win = 0;
    chk("mem_en", 32'(mem_en), 32'(win != 0));
    chk("mem_wren", 32'(mem_wren), 32'(win == 3));
    if (win == 1) chk("mem_addr_i", 32'(mem_addr), 32'(widx(instr_addr)));
    if (win >= 2) chk("mem_addr_d", 32'(mem_addr), 32'(widx(data_addr)));

    @(posedge clk);
    if (win == 1) m_rd = ref_mem[widx(instr_addr)];
    if (win == 2) m_rd = ref_mem[widx(data_addr)];
    if (win == 3)
      for (int b = 0; b < 4; b++)
        if (data_wr_mask[b]) ref_mem[widx(data_addr)][8*b +: 8] = data_wr_data[8*b +: 8];
    if (!rst) begin
      m_prev = win;
      m_loss = (instr_req && win >= 2) ? m_loss + 1 : 0;
      if (instr_req && dreq && m_conf < 65535) m_conf++;
    end
    #1;
  endtask

  task automatic idle();
    instr_req = 0; data_rd_req = 0; data_wr_req = 0;
  endtask

  int ig0, dg0;
  bit [31:0] old16;

  initial begin
    tick(); tick();
    rst = 1'b0;
    tick();

    // Preload every word so later reads have defined contents.
    for (int i = 0; i < DEPTH; i++) begin
      data_wr_req = 1; data_addr = 32'(i) << 2; data_wr_data = $urandom; data_wr_mask = 4'hF;
      tick();
    end
    idle(); tick();

    // Instruction-only fetch held three cycles.
    ig0 = cnt_ig; dg0 = cnt_dg;
    instr_req = 1; instr_addr = 32'h10;
    tick(); chk("io_addr", 32'(s_addr), 32'd4); chk("io_c1_gnt", 32'(s_ig), 0);
    tick(); tick();
    idle(); tick(); chk("io_last_gnt", 32'(s_ig), 1);
    tick(); chk("io_count_i", 32'(cnt_ig - ig0), 3); chk("io_count_d", 32'(cnt_dg - dg0), 0);

    // Single collision: data wins, one conflict.
    instr_req = 1; instr_addr = 32'h44; data_rd_req = 1; data_addr = 32'h20;
    tick();
    idle(); tick();
    chk("col_dgnt", 32'(s_dg), 1); chk("col_ignt", 32'(s_ig), 0);
    chk("col_data", s_data, ref_mem[8]); chk("col_cnt", 32'(s_cc), 1);
    tick();

    // Held collision: instr wins once every LIMIT+1 cycles.
    ig0 = cnt_ig; dg0 = cnt_dg;
    instr_req = 1; data_rd_req = 1;
    for (int i = 0; i < 25; i++) begin
      instr_addr = $urandom; data_addr = $urandom; tick();
    end
    idle(); tick();
    chk("starve_i", 32'(cnt_ig - ig0), 5); chk("starve_d", 32'(cnt_dg - dg0), 20);
    tick();

    // Partial store, then read back.
    old16 = ref_mem[16];
    dg0 = cnt_dg;
    data_wr_req = 1; data_addr = 32'h40; data_wr_data = 32'hA5A5A5A5; data_wr_mask = 4'b0011;
    tick();
    idle(); tick(); chk("st_gnt", 32'(cnt_dg - dg0), 1);
    data_rd_req = 1; data_addr = 32'h40; tick();
    idle(); tick(); chk("st_read", s_data, {old16[31:16], 16'hA5A5});

    // Reset asserted in the winning cycle drops the access.
    instr_req = 1; instr_addr = 32'h10; data_rd_req = 1; data_addr = 32'h24; rst = 1;
    tick(); chk("rst_cnt", 32'(s_cc), 0);
    rst = 0; idle(); tick();
    chk("rst_no_ig", 32'(s_ig), 0); chk("rst_no_dg", 32'(s_dg), 0);
    instr_req = 1; instr_addr = 32'h18; tick();
    idle(); tick(); chk("rst_fetch_gnt", 32'(s_ig), 1); chk("rst_fetch_data", s_data, ref_mem[6]);

    // Random traffic with aliasing addresses and mixed read/write requests.
    for (int i = 0; i < 3000; i++) begin
      instr_req    = ($urandom_range(0, 3) != 0);
      data_rd_req  = ($urandom_range(0, 2) == 0);
      data_wr_req  = ($urandom_range(0, 3) == 0);
      instr_addr   = $urandom; data_addr = $urandom;
      data_wr_data = $urandom; data_wr_mask = 4'($urandom);
      tick();
    end
    idle(); tick();

    // Saturation of the conflict counter.
    rst = 1; tick(); rst = 0; tick();
    instr_req = 1; data_rd_req = 1;
    for (int i = 0; i < 70000; i++) begin
      instr_addr = $urandom; data_addr = $urandom; tick();
    end
    idle(); tick(); chk("sat_cnt", 32'(s_cc), 32'hFFFF);
    tick(); chk("sat_hold", 32'(s_cc), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/kronos_spsram_arbiter.md
KRONOS_SPSRAM_ARBITER -- requirements
Module: kronos_spsram_arbiter

Interface
REQ-001 SHALL have parameter MEMSIZE, default 11, log2 of SRAM depth in 32-bit words.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, max consecutive cycles an instruction request may lose to data.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_addr  in  32  byte address of the instruction fetch.
- instr_req  in  1  fetch request.
- instr_gnt  out  1  fetch done; instr_data valid this cycle.
- instr_data  out  32  fetch read data.
- data_addr  in  32  byte address of the data access.
- data_wr_data  in  32  store data.
- data_wr_mask  in  4  store byte enables.
- data_rd_req  in  1  load request.
- data_wr_req  in  1  store request.
- data_gnt  out  1  data access done; data_rd_data valid for loads.
- data_rd_data  out  32  load read data.
- mem_addr  out  MEMSIZE  SRAM word address.
- mem_wdata  out  32  SRAM write data.
- mem_wmask  out  4  SRAM byte write mask.
- mem_en  out  1  SRAM access enable.
- mem_wren  out  1  SRAM write enable.
- mem_rdata  in  32  SRAM read data, one cycle after mem_en.
- conflict_cnt  out  16  saturating count of cycles with both requesters active.

Function
REQ-004 SHALL arbitrate combinationally each cycle. data_req = data_rd_req | data_wr_req.
REQ-005 SHALL give data the win over instr when both request, unless starve_cnt == STARVE_LIMIT; then instr wins.
REQ-006 starve_cnt SHALL increment when instr_req is high and loses, clear when instr wins or instr_req is low, and never exceed STARVE_LIMIT.
REQ-007 SHALL drive:
- mem_en = instr_req | data_req.
- mem_addr = winner address bits [2+:MEMSIZE].
- mem_wren = data_wr_req & data wins.
- mem_wdata = data_wr_data and mem_wmask = data_wr_mask, always.
REQ-008 SHALL assert the winner's gnt exactly one cycle after the winning cycle, for one cycle; the loser's gnt SHALL stay low.
REQ-009 SHALL route mem_rdata combinationally to both instr_data and data_rd_data; they are defined only in the gnt cycle.
REQ-010 SHALL treat each requesting cycle as a new access. A requester holding req during its gnt cycle is rearbitrated back-to-back, with no bubble.
REQ-011 SHALL treat simultaneous data_rd_req and data_wr_req as a single write; one data_gnt.
REQ-012 SHALL increment conflict_cnt when instr_req & data_req, saturating at 16'hFFFF.
REQ-013 SHALL ignore address bits above 2+MEMSIZE; wrap-around aliasing is intended.
REQ-014 SHALL assert at most one of instr_gnt and data_gnt in any cycle.

Reset
REQ-015 While rst is high: instr_gnt, data_gnt, starve_cnt and conflict_cnt SHALL be 0; combinational mem_* outputs follow the inputs.
REQ-016 An access won in the cycle rst asserts SHALL be dropped, with no gnt after release; the first gnt comes one cycle after the first post-reset winning cycle.

Structure
REQ-017 The arb_owner_t enum {OWNER_NONE, OWNER_INSTR, OWNER_DATA} for the registered winner SHALL live in kronos_types.
REQ-018 SHALL be one module with no sub-modules; the starvation counter is inline, width $clog2(STARVE_LIMIT+1).

Verification
REQ-019 The bench SHALL use spsram32_model, depth 2**MEMSIZE, as the SRAM and cover:
- Instr only: instr_req=1, instr_addr=0x10 for 3 cycles -> mem_addr=4; instr_gnt high on cycles 2-4; instr_data=MEM[4].
- Collision: data_rd_req and instr_req in the same cycle, data_addr=0x20 -> data_gnt next cycle, data_rd_data=MEM[8], no instr_gnt; conflict_cnt=1.
- Starvation: data_rd_req and instr_req held high, STARVE_LIMIT=4 -> instr_gnt once every 5 cycles; data_gnt in the other 4.
- Store: data_wr_req, data_addr=0x40, data_wr_data=0xA5A5A5A5, data_wr_mask=4'b0011 -> MEM[16][15:0]=0xA5A5, upper half unchanged; one data_gnt.
- Reset mid-access: rst asserted in the winning cycle -> no gnt; counters 0; a fetch after release gets gnt after 1 cycle.
- Saturation: 70000 conflict cycles -> conflict_cnt holds 16'hFFFF.
